fp_div_sqrt_issue_unit: RTL



---
 rtl/fp_div_sqrt_issue_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fp_div_sqrt_issue_unit.sv
// Issue front-end for the FP32 iterative divide/sqrt unit: in-order op queue,
// single-op-in-flight req/finished handshake, tagged valid/ready result port, flush.
module fp_div_sqrt_issue_unit #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned TAG_WIDTH   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_lhs,
  input  logic [31:0]          in_rhs,
  input  logic                 in_is_divide,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 dsq_req,
  output logic [31:0]          dsq_lhs,
  output logic [31:0]          dsq_rhs,
  output logic                 dsq_is_divide,
  input  logic                 dsq_finished,
  input  logic [31:0]          dsq_result,
  output logic                 busy
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]          q_lhs [QUEUE_DEPTH];
  logic [31:0]          q_rhs [QUEUE_DEPTH];
  logic                 q_div [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0] q_tag [QUEUE_DEPTH];

  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push, pop, not_empty, can_issue;

  logic                 killed_q, killed_d;
  logic [TAG_WIDTH-1:0] cur_tag_q, cur_tag_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_result_q, out_result_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

  assign not_empty = (count != '0);
  assign in_ready  = (count < CNT_W'(QUEUE_DEPTH)) && !flush;
  assign push      = in_valid && in_ready;
  assign can_issue = not_empty && dsq_finished && !flush;

  assign dsq_lhs       = q_lhs[rd_ptr];
  assign dsq_rhs       = q_rhs[rd_ptr];
  assign dsq_is_divide = q_div[rd_ptr];

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = not_empty || (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        q_lhs[i] <= '0;
        q_rhs[i] <= '0;
        q_div[i] <= 1'b0;
        q_tag[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_lhs[wr_ptr] <= in_lhs;
        q_rhs[wr_ptr] <= in_rhs;
        q_div[wr_ptr] <= in_is_divide;
        q_tag[wr_ptr] <= in_tag;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      killed_q     <= 1'b0;
      cur_tag_q    <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      killed_q     <= killed_d;
      cur_tag_q    <= cur_tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    killed_d     = killed_q;
    cur_tag_d    = cur_tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    pop          = 1'b0;
    dsq_req      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (can_issue) begin
          dsq_req   = 1'b1;
          pop       = 1'b1;
          cur_tag_d = q_tag[rd_ptr];
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        // The unit cannot be aborted: a flushed op is only marked, and its result dropped later.
        if (dsq_finished) begin
          if (killed_q || flush) begin
            killed_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            out_result_d = dsq_result;
            out_tag_d    = cur_tag_q;
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
          end
        end else if (flush) begin
          killed_d = 1'b1;
        end
      end
      S_DONE: begin
        if (flush) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (can_issue) begin
            dsq_req   = 1'b1;
            pop       = 1'b1;
            cur_tag_d = q_tag[rd_ptr];
            state_d   = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
